segre_mm_arbiter: RTL and testbench

SEGRE_MM_ARBITER -- requirements
Module: segre_mm_arbiter

---
 rtl/segre_pkg.sv | 40 ++++
 rtl/segre_mm_arbiter_if.sv | 44 ++++
 rtl/segre_rr_picker.sv | 49 ++++
 rtl/segre_mm_arbiter.sv | 167 ++++++++++++++++
 tb/tb_segre_mm_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/segre_pkg.sv
// -----------------------------------------------------------------------------
// segre_pkg
//   Shared types and size constants for the segre memory subsystem.
//   - ADDR_SIZE / WORD_SIZE / LANE_SIZE : default address, store-word and
//     read-lane widths.
//   - memop_data_type_e : store size qualifier.
//   - arb_mode_e        : main-memory arbitration policy.
//   - mm_arb_state_e    : main-memory arbiter FSM states.
//   - next_idx()        : modulo-N increment used for the round-robin pointer.
// -----------------------------------------------------------------------------
package segre_pkg;

    localparam int ADDR_SIZE = 32;
    localparam int WORD_SIZE = 32;
    localparam int LANE_SIZE = 128;

    typedef enum logic [1:0] {
        MEMOP_BYTE,
        MEMOP_HALF,
        MEMOP_WORD
    } memop_data_type_e;

    typedef enum logic {
        ARB_RR,
        ARB_FIXED
    } arb_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mm_arb_state_e;

    // (cur + 1) mod n, written without a divider.
    function automatic int next_idx(input int cur, input int n);
        return (cur >= n - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/segre_mm_arbiter_if.sv
// -----------------------------------------------------------------------------
// segre_mm_arbiter_if
//   Main-memory side bus of the arbiter.
//   master : the arbiter (drives rd/wr request, address, store data and size;
//            receives completion and read lane).
//   slave  : the main-memory model / controller.
//   mm_data_rdy_i completes both reads and writes.
// -----------------------------------------------------------------------------
interface segre_mm_arbiter_if #(
    parameter int ADDR_SIZE = segre_pkg::ADDR_SIZE,
    parameter int WORD_SIZE = segre_pkg::WORD_SIZE,
    parameter int LANE_SIZE = segre_pkg::LANE_SIZE
);
    import segre_pkg::*;

    logic                 mm_rd_o;
    logic                 mm_wr_o;
    logic [ADDR_SIZE-1:0] mm_addr_o;
    logic [WORD_SIZE-1:0] mm_wr_data_o;
    memop_data_type_e     mm_wr_data_type_o;
    logic                 mm_data_rdy_i;
    logic [LANE_SIZE-1:0] mm_rd_data_i;

    modport master (
        output mm_rd_o,
        output mm_wr_o,
        output mm_addr_o,
        output mm_wr_data_o,
        output mm_wr_data_type_o,
        input  mm_data_rdy_i,
        input  mm_rd_data_i
    );

    modport slave (
        input  mm_rd_o,
        input  mm_wr_o,
        input  mm_addr_o,
        input  mm_wr_data_o,
        input  mm_wr_data_type_o,
        output mm_data_rdy_i,
        output mm_rd_data_i
    );

endinterface

// File: rtl/segre_rr_picker.sv
// -----------------------------------------------------------------------------
// segre_rr_picker
//   Purely combinational winner selection.
//   req_i     : per-channel request vector.
//   start_i   : first index searched in round-robin mode.
//   mode_i    : ARB_RR searches from start_i upward with wrap;
//               ARB_FIXED always searches from index 0.
//   gnt_idx_o : index of the winning channel (0 when nothing requests).
//   gnt_vld_o : at least one channel is requesting.
// -----------------------------------------------------------------------------
module segre_rr_picker
    import segre_pkg::*;
#(
    parameter int NUM_CH = 2
)(
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [$clog2(NUM_CH)-1:0] start_i,
    input  arb_mode_e                 mode_i,
    output logic [$clog2(NUM_CH)-1:0] gnt_idx_o,
    output logic                      gnt_vld_o
);

    localparam int IDX_W = $clog2(NUM_CH);

    int               base_c;
    int               pos_c;
    logic [IDX_W-1:0] sel_c;

    always_comb begin
        base_c    = (mode_i == ARB_FIXED) ? 0 : int'(start_i);
        pos_c     = 0;
        sel_c     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = |req_i;
        // Walk offsets from farthest to nearest: the nearest active requester
        // is the last one written and therefore wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            pos_c = base_c + k;
            if (pos_c >= NUM_CH) begin
                pos_c = pos_c - NUM_CH;
            end
            sel_c = IDX_W'(pos_c);
            if (req_i[sel_c]) begin
                gnt_idx_o = sel_c;
            end
        end
    end

endmodule

// File: rtl/segre_mm_arbiter.sv
// -----------------------------------------------------------------------------
// segre_mm_arbiter
//   Shares one main-memory port between NUM_CH requesters (I$, D$, store
//   buffer drain, ...). One transaction is outstanding at a time.
//
//   clk_i, rsn_i    : clock, synchronous active-low reset.
//   req_i           : per-channel request, held until that channel's rsp_rdy_o.
//   req_wr_i        : 1 = write, 0 = lane read.
//   req_addr_i      : per-channel address.
//   req_wr_data_i   : per-channel store data.
//   req_wr_type_i   : per-channel store size.
//   rsp_rdy_o       : one-cycle completion pulse to the owning channel.
//   rsp_data_o      : last read lane, shared by all channels.
//   busy_o          : a transaction is outstanding (ISSUE/WAIT/RESP).
//   mm_bus          : main-memory bus (master side).
//
//   Flow: IDLE (pick + latch) -> ISSUE (request visible) -> WAIT (until
//   mm_data_rdy_i) -> RESP (completion pulse) -> IDLE. Every output is a
//   flop, so req_i never reaches mm_* combinationally.
// -----------------------------------------------------------------------------
module segre_mm_arbiter
    import segre_pkg::*;
#(
    parameter int        NUM_CH    = 2,
    parameter arb_mode_e ARB_MODE  = ARB_RR,
    parameter int        ADDR_SIZE = segre_pkg::ADDR_SIZE,
    parameter int        WORD_SIZE = segre_pkg::WORD_SIZE,
    parameter int        LANE_SIZE = segre_pkg::LANE_SIZE
)(
    input  logic                                clk_i,
    input  logic                                rsn_i,
    input  logic             [NUM_CH-1:0]       req_i,
    input  logic             [NUM_CH-1:0]       req_wr_i,
    input  logic [NUM_CH-1:0][ADDR_SIZE-1:0]    req_addr_i,
    input  logic [NUM_CH-1:0][WORD_SIZE-1:0]    req_wr_data_i,
    input  memop_data_type_e [NUM_CH-1:0]       req_wr_type_i,
    output logic             [NUM_CH-1:0]       rsp_rdy_o,
    output logic             [LANE_SIZE-1:0]    rsp_data_o,
    output logic                                busy_o,
    segre_mm_arbiter_if.master                  mm_bus
);

    localparam int IDX_W = $clog2(NUM_CH);

    // Fields of the granted request, frozen for the whole transaction.
    typedef struct packed {
        logic                 wr;
        logic [ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
        memop_data_type_e     typ;
    } mm_req_t;

    mm_arb_state_e    state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q,  last_d;
    mm_req_t          cur_q,   cur_d;
    logic             mm_rd_q, mm_rd_d;
    logic             mm_wr_q, mm_wr_d;
    logic [NUM_CH-1:0]    rsp_rdy_q,  rsp_rdy_d;
    logic [LANE_SIZE-1:0] rsp_data_q, rsp_data_d;
    logic             busy_q,  busy_d;

    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;

    assign start_idx = IDX_W'(next_idx(int'(last_q), NUM_CH));

    segre_rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .req_i     (req_i),
        .start_i   (start_idx),
        .mode_i    (ARB_MODE),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cur_d      = cur_q;
        mm_rd_d    = mm_rd_q;
        mm_wr_d    = mm_wr_q;
        rsp_rdy_d  = '0;
        rsp_data_d = rsp_data_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    owner_d    = gnt_idx;
                    last_d     = gnt_idx;
                    cur_d.wr   = req_wr_i[gnt_idx];
                    cur_d.addr = req_addr_i[gnt_idx];
                    cur_d.data = req_wr_data_i[gnt_idx];
                    cur_d.typ  = req_wr_type_i[gnt_idx];
                    // Raised on this edge so the request is visible in ISSUE.
                    mm_rd_d    = ~req_wr_i[gnt_idx];
                    mm_wr_d    = req_wr_i[gnt_idx];
                    busy_d     = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mm_bus.mm_data_rdy_i) begin
                    if (!cur_q.wr) begin
                        rsp_data_d = mm_bus.mm_rd_data_i;
                    end
                    mm_rd_d   = 1'b0;
                    mm_wr_d   = 1'b0;
                    rsp_rdy_d = NUM_CH'(1) << owner_q;
                    state_d   = RESP;
                end
            end
            RESP: begin
                // req_i is not looked at here, so the owner cannot be
                // re-granted before the following IDLE cycle.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            // Points at the last channel so channel 0 is searched first.
            last_q     <= IDX_W'(NUM_CH - 1);
            cur_q      <= '0;
            mm_rd_q    <= 1'b0;
            mm_wr_q    <= 1'b0;
            rsp_rdy_q  <= '0;
            rsp_data_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cur_q      <= cur_d;
            mm_rd_q    <= mm_rd_d;
            mm_wr_q    <= mm_wr_d;
            rsp_rdy_q  <= rsp_rdy_d;
            rsp_data_q <= rsp_data_d;
            busy_q     <= busy_d;
        end
    end

    assign rsp_rdy_o                = rsp_rdy_q;
    assign rsp_data_o               = rsp_data_q;
    assign busy_o                   = busy_q;
    assign mm_bus.mm_rd_o           = mm_rd_q;
    assign mm_bus.mm_wr_o           = mm_wr_q;
    assign mm_bus.mm_addr_o         = cur_q.addr;
    assign mm_bus.mm_wr_data_o      = cur_q.data;
    assign mm_bus.mm_wr_data_type_o = cur_q.typ;

endmodule

// File: tb/tb_segre_mm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_segre_mm_arbiter
//   dut_rr : NUM_CH=3, ARB_RR, scoreboard of expected transactions.
//   dut_fx : NUM_CH=2, ARB_FIXED, grant order collected and compared.
//   All sampling and input driving happens at the falling edge via tick().
// -----------------------------------------------------------------------------
module tb_segre_mm_arbiter;
    import segre_pkg::*;

    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int WW  = 32;
    localparam int LW  = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rsn;

    // ---------------- round-robin DUT ----------------
    logic             [NCH-1:0]   a_req, a_wr;
    logic [NCH-1:0][AW-1:0]       a_addr;
    logic [NCH-1:0][WW-1:0]       a_data;
    memop_data_type_e [NCH-1:0]   a_typ;
    logic             [NCH-1:0]   a_rsp_rdy;
    logic             [LW-1:0]    a_rsp_data;
    logic                         a_busy;

    segre_mm_arbiter_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .LANE_SIZE(LW)) a_mm ();

    segre_mm_arbiter #(
        .NUM_CH(NCH), .ARB_MODE(ARB_RR), .ADDR_SIZE(AW), .WORD_SIZE(WW), .LANE_SIZE(LW)
    ) dut_rr (
        .clk_i(clk), .rsn_i(rsn), .req_i(a_req), .req_wr_i(a_wr), .req_addr_i(a_addr),
        .req_wr_data_i(a_data), .req_wr_type_i(a_typ), .rsp_rdy_o(a_rsp_rdy),
        .rsp_data_o(a_rsp_data), .busy_o(a_busy), .mm_bus(a_mm)
    );

    // ---------------- fixed-priority DUT ----------------
    logic             [1:0]       b_req, b_wr;
    logic [1:0][AW-1:0]           b_addr;
    logic [1:0][WW-1:0]           b_data;
    memop_data_type_e [1:0]       b_typ;
    logic             [1:0]       b_rsp_rdy;
    logic             [LW-1:0]    b_rsp_data;
    logic                         b_busy;

    segre_mm_arbiter_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .LANE_SIZE(LW)) b_mm ();

    segre_mm_arbiter #(
        .NUM_CH(2), .ARB_MODE(ARB_FIXED), .ADDR_SIZE(AW), .WORD_SIZE(WW), .LANE_SIZE(LW)
    ) dut_fx (
        .clk_i(clk), .rsn_i(rsn), .req_i(b_req), .req_wr_i(b_wr), .req_addr_i(b_addr),
        .req_wr_data_i(b_data), .req_wr_type_i(b_typ), .rsp_rdy_o(b_rsp_rdy),
        .rsp_data_o(b_rsp_data), .busy_o(b_busy), .mm_bus(b_mm)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int               ch;
        logic             wr;
        logic [AW-1:0]    addr;
        logic [WW-1:0]    data;
        memop_data_type_e typ;
        int               lat;   // WAIT cycle in which memory completes
    } exp_t;

    typedef struct {
        logic [1:0]       ch;
        logic             wr;
        logic [AW-1:0]    addr;
        logic [WW-1:0]    data;
        memop_data_type_e typ;
        int               lat;
        int               exp_n;    // falling edges from request to rsp_rdy_o
        logic [NCH-1:0]   exp_rdy;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[6];
    int         checks = 0;
    int         errors = 0;
    int         a_cnt  = 0;
    int         a_act  = 0;
    int         b_cnt  = 0;
    logic       a_spur = 1'b0;
    logic [LW-1:0] last_lane = '0;
    int         b_got[$];

    function automatic logic [LW-1:0] lane_of(input logic [AW-1:0] a);
        return {4{32'hA5A5_A5A5 ^ (a - 32'h100)}};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: sample at the falling edge, run the scoreboard, then drive the
    // memory responses for the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (a_mm.mm_rd_o || a_mm.mm_wr_o) begin
            if (a_cnt == 0) a_act = 0;
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", 128'(1), 128'(0));
            end else begin
                e = exp_q[0];
                chk("mm_fields",
                    128'({a_mm.mm_rd_o, a_mm.mm_wr_o, a_mm.mm_addr_o, a_mm.mm_wr_data_o, a_mm.mm_wr_data_type_o}),
                    128'({~e.wr, e.wr, e.addr, e.data, e.typ}));
            end
            a_cnt++;
            a_act++;
        end else begin
            a_cnt = 0;
        end
        if (a_rsp_rdy != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 128'(a_rsp_rdy), 128'(0));
            end else begin
                e = exp_q.pop_front();
                if (!e.wr) last_lane = lane_of(e.addr);
                chk("rsp_owner",     128'(a_rsp_rdy), 128'(1) << e.ch);
                chk("rsp_data",      a_rsp_data, last_lane);
                chk("rsp_mm_cycles", 128'(a_act), 128'(e.lat + 1));
                chk("rsp_busy",      128'(a_busy), 128'(1));
            end
        end
        a_mm.mm_data_rdy_i = a_spur || ((a_mm.mm_rd_o || a_mm.mm_wr_o) &&
                             exp_q.size() != 0 && a_cnt == exp_q[0].lat + 1);
        a_mm.mm_rd_data_i  = lane_of(a_mm.mm_addr_o);

        if (b_mm.mm_rd_o || b_mm.mm_wr_o) b_cnt++; else b_cnt = 0;
        b_mm.mm_data_rdy_i = (b_cnt == 2);
        b_mm.mm_rd_data_i  = '0;
        if (b_rsp_rdy == 2'b01)      b_got.push_back(0);
        else if (b_rsp_rdy == 2'b10) b_got.push_back(1);
        else if (b_rsp_rdy != 2'b00) b_got.push_back(9);
    endtask

    task automatic drive(input logic [1:0] ch, input logic wr, input logic [AW-1:0] addr,
                         input logic [WW-1:0] data, input memop_data_type_e typ, input int lat);
        a_wr[ch]   = wr;
        a_addr[ch] = addr;
        a_data[ch] = data;
        a_typ[ch]  = typ;
        exp_q.push_back('{ch: int'(ch), wr: wr, addr: addr, data: data, typ: typ, lat: lat});
    endtask

    task automatic wait_pulses(input int want, input int max_ticks, output int got);
        got = 0;
        for (int t = 0; t < max_ticks && got < want; t++) begin
            tick();
            if (a_rsp_rdy != '0) got++;
        end
    endtask

    initial begin
        int n, got;
        logic seen;
        logic [NCH-1:0] rdy;

        rsn = 1'b0;
        a_req = '0; a_wr = '0; a_addr = '0; a_data = '0;
        b_req = '0; b_wr = '0; b_addr = '0; b_data = '0;
        for (int i = 0; i < NCH; i++) a_typ[i] = MEMOP_BYTE;
        for (int i = 0; i < 2; i++)   b_typ[i] = MEMOP_WORD;
        a_mm.mm_data_rdy_i = 1'b0; a_mm.mm_rd_data_i = '0;
        b_mm.mm_data_rdy_i = 1'b0; b_mm.mm_rd_data_i = '0;

        // Reset state
        repeat (3) tick();
        chk("reset_busy",     128'(a_busy), 128'(0));
        chk("reset_rsp_rdy",  128'(a_rsp_rdy), 128'(0));
        chk("reset_rsp_data", a_rsp_data, 128'(0));
        chk("reset_rd_wr",    128'({a_mm.mm_rd_o, a_mm.mm_wr_o}), 128'(0));
        chk("reset_mm_bus",   128'({a_mm.mm_addr_o, a_mm.mm_wr_data_o, a_mm.mm_wr_data_type_o}), 128'(0));
        rsn = 1'b1;
        tick();

        // Single transactions; the last one is on ch2 so the RR pointer
        // restarts at ch0 for the fairness sequence.
        vecs[0] = '{ch: 2'd0, wr: 1'b0, addr: 32'h100,      data: 32'h0,        typ: MEMOP_WORD, lat: 3, exp_n: 5, exp_rdy: 3'b001};
        vecs[1] = '{ch: 2'd1, wr: 1'b1, addr: 32'h40,       data: 32'hDEADBEEF, typ: MEMOP_HALF, lat: 1, exp_n: 3, exp_rdy: 3'b010};
        vecs[2] = '{ch: 2'd2, wr: 1'b0, addr: 32'h200,      data: 32'h0,        typ: MEMOP_BYTE, lat: 1, exp_n: 3, exp_rdy: 3'b100};
        vecs[3] = '{ch: 2'd0, wr: 1'b1, addr: 32'h3FC,      data: 32'h12345678, typ: MEMOP_BYTE, lat: 2, exp_n: 4, exp_rdy: 3'b001};
        vecs[4] = '{ch: 2'd1, wr: 1'b0, addr: 32'h80,       data: 32'h0,        typ: MEMOP_WORD, lat: 5, exp_n: 7, exp_rdy: 3'b010};
        vecs[5] = '{ch: 2'd2, wr: 1'b1, addr: 32'hFFFFFFFC, data: 32'hCAFEF00D, typ: MEMOP_WORD, lat: 1, exp_n: 3, exp_rdy: 3'b100};
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].ch, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].typ, vecs[i].lat);
            a_req[vecs[i].ch] = 1'b1;
            n = 0; seen = 1'b0; rdy = '0;
            while (!seen && n < 40) begin
                tick();
                n++;
                if (a_rsp_rdy != '0) begin
                    seen = 1'b1;
                    rdy  = a_rsp_rdy;
                end
            end
            chk("vec_latency", 128'(n), 128'(vecs[i].exp_n));
            chk("vec_rsp_rdy", 128'(rdy), 128'(vecs[i].exp_rdy));
            a_req = '0;
            tick();
            chk("vec_pulse_len", 128'(a_rsp_rdy), 128'(0));
        end

        // Round-robin fairness with all channels requesting continuously.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NCH; c++)
                drive(2'(c), 1'b0, 32'h1000 + 32'(c * 16), 32'h0, MEMOP_WORD, 1);
        a_req = 3'b111;
        wait_pulses(6, 200, got);
        a_req = '0;
        chk("rr_pulses", 128'(got), 128'(6));
        repeat (3) tick();
        chk("rr_queue_empty", 128'(exp_q.size()), 128'(0));

        // Reset in WAIT abandons the transaction; RR restarts at ch0.
        drive(2'd1, 1'b0, 32'h500, 32'h0, MEMOP_WORD, 10);
        a_req[1] = 1'b1;
        repeat (3) tick();
        chk("pre_reset_busy", 128'(a_busy), 128'(1));
        rsn = 1'b0;
        tick();
        chk("wait_reset_busy",     128'(a_busy), 128'(0));
        chk("wait_reset_rsp_rdy",  128'(a_rsp_rdy), 128'(0));
        chk("wait_reset_rd_wr",    128'({a_mm.mm_rd_o, a_mm.mm_wr_o}), 128'(0));
        chk("wait_reset_addr",     128'(a_mm.mm_addr_o), 128'(0));
        chk("wait_reset_rsp_data", a_rsp_data, 128'(0));
        exp_q.delete();
        last_lane = '0;
        a_req = '0;
        rsn = 1'b1;
        tick();
        for (int c = 0; c < NCH; c++)
            drive(2'(c), 1'b0, 32'h2000 + 32'(c * 16), 32'h0, MEMOP_WORD, 1);
        a_req = 3'b111;
        wait_pulses(3, 100, got);
        a_req = '0;
        chk("post_reset_pulses", 128'(got), 128'(3));
        repeat (2) tick();

        // Spurious completion in IDLE is ignored.
        a_spur = 1'b1;
        repeat (3) begin
            tick();
            chk("spur_idle", 128'({a_busy, a_rsp_rdy, a_mm.mm_rd_o, a_mm.mm_wr_o}), 128'(0));
        end
        a_spur = 1'b0;
        repeat (2) tick();
        chk("spur_rsp_data", a_rsp_data, last_lane);

        // Requester withdraws in WAIT; completion still pulses once.
        drive(2'd2, 1'b0, 32'h2C0, 32'h0, MEMOP_HALF, 4);
        a_req[2] = 1'b1;
        repeat (3) tick();
        a_req[2] = 1'b0;
        wait_pulses(2, 15, got);
        chk("drop_pulses", 128'(got), 128'(1));
        chk("drop_queue_empty", 128'(exp_q.size()), 128'(0));

        // Fixed priority: ch1 starves until ch0 withdraws.
        b_got.delete();
        b_addr[0] = 32'h10; b_addr[1] = 32'h20;
        b_req = 2'b11;
        for (int t = 0; t < 200 && b_got.size() < 4; t++) tick();
        b_req[0] = 1'b0;
        for (int t = 0; t < 200 && b_got.size() < 5; t++) tick();
        b_req = '0;
        for (int i = 0; i < 5; i++)
            chk("fixed_grant", 128'((b_got.size() > i) ? b_got[i] : -1), 128'((i < 4) ? 0 : 1));
        repeat (3) tick();
        chk("fixed_idle_busy", 128'(b_busy), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
